// File: rtl/mem_access_pkg.sv
// mem_access_pkg: op/state encodings and size helpers
// shared by the load/store memory access unit.
package mem_access_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_SW  = 3'b011,
      OP_LBU = 3'b100,
      OP_LHU = 3'b101,
      OP_SB  = 3'b110,
      OP_SH  = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   function automatic size_e op_size(op_e op);
      size_e s;
      s = SZ_W;
      unique case (1'b1)
         (op == OP_LB) || (op == OP_LBU) || (op == OP_SB): s = SZ_B;
         (op == OP_LH) || (op == OP_LHU) || (op == OP_SH): s = SZ_H;
         default: s = SZ_W;
      endcase
      return s;
   endfunction

   function automatic logic is_store(op_e op);
      return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
   endfunction

   function automatic logic is_signed(op_e op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

   function automatic logic is_misaligned(op_e op, logic [1:0] off);
      size_e s;
      s = op_size(op);
      return ((s == SZ_H) && off[0]) || ((s == SZ_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake plus
// the big-endian data RAM port of the access unit.
interface mem_access_unit_if;
   import mem_access_pkg::*;

   logic        req_valid;
   logic        req_ready;
   op_e         req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic [31:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_rd;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_misalign,
      output mem_a, mem_we, mem_wd, mem_byteenable
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_misalign,
      input  mem_a, mem_we, mem_wd, mem_byteenable
   );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for big-endian RAM;
// store enables/replication, load extract/extend, alignment.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  op_e         op,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rd,
   output logic [3:0]  be,
   output logic [31:0] wd,
   output logic [31:0] rdata,
   output logic        misalign
);

   size_e       sz;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   logic        sx;

   assign sz       = op_size(op);
   assign sx       = is_signed(op);
   assign misalign = is_misaligned(op, off);

   // offset 0 lives in the top byte lane
   always_comb begin
      bsel = rd[31:24];
      unique case (off)
         2'd0: bsel = rd[31:24];
         2'd1: bsel = rd[23:16];
         2'd2: bsel = rd[15:8];
         2'd3: bsel = rd[7:0];
         default: bsel = rd[31:24];
      endcase
   end

   assign hsel = off[1] ? rd[15:0] : rd[31:16];

   always_comb begin
      be    = 4'b1111;
      wd    = wdata;
      rdata = rd;
      unique case (1'b1)
         sz == SZ_B: begin
            be    = 4'b1000 >> off;
            wd    = {4{wdata[7:0]}};
            rdata = {{24{sx & bsel[7]}}, bsel};
         end
         sz == SZ_H: begin
            be    = off[1] ? 4'b0011 : 4'b1100;
            wd    = {2{wdata[15:0]}};
            rdata = {{16{sx & hsel[15]}}, hsel};
         end
         default: begin
            be    = 4'b1111;
            wd    = wdata;
            rdata = rd;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator
// for the synchronous-read big-endian data RAM.
module mem_access_unit
   import mem_access_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);

   state_e      state;
   op_e         op_q;
   logic [1:0]  off_q;
   logic        acc;
   op_e         op_s;
   logic [1:0]  off_s;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [31:0] rdata;
   logic        mis;

   assign acc = bus.req_valid & bus.req_ready;

   // live request steers the lanes in IDLE, latched one afterwards
   assign op_s  = (state == ST_IDLE) ? bus.req_op : op_q;
   assign off_s = (state == ST_IDLE) ? bus.req_addr[1:0] : off_q;

   mem_lane_align u_align (
      .op       (op_s),
      .off      (off_s),
      .wdata    (bus.req_wdata),
      .rd       (bus.mem_rd),
      .be       (be),
      .wd       (wd),
      .rdata    (rdata),
      .misalign (mis)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         op_q               <= OP_LB;
         off_q              <= 2'b00;
         bus.req_ready      <= 1'b1;
         bus.resp_valid     <= 1'b0;
         bus.resp_rdata     <= 32'h0;
         bus.resp_misalign  <= 1'b0;
         bus.mem_a          <= 32'h0;
         bus.mem_we         <= 1'b0;
         bus.mem_wd         <= 32'h0;
         bus.mem_byteenable <= 4'h0;
      end else begin
         bus.mem_we     <= 1'b0;
         bus.resp_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (acc) begin
                  op_q          <= bus.req_op;
                  off_q         <= bus.req_addr[1:0];
                  bus.req_ready <= 1'b0;
                  if (mis) begin
                     state             <= ST_RESP;
                     bus.resp_valid    <= 1'b1;
                     bus.resp_misalign <= 1'b1;
                     bus.resp_rdata    <= 32'h0;
                  end else begin
                     bus.mem_a          <= {bus.req_addr[31:2], 2'b00};
                     bus.mem_byteenable <= be;
                     bus.mem_wd         <= wd;
                     if (is_store(bus.req_op)) begin
                        state      <= ST_WRITE;
                        bus.mem_we <= 1'b1;
                     end else begin
                        state <= ST_ISSUE;
                     end
                  end
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               state             <= ST_RESP;
               bus.resp_valid    <= 1'b1;
               bus.resp_rdata    <= rdata;
               bus.resp_misalign <= 1'b0;
            end
            ST_WRITE: begin
               state             <= ST_RESP;
               bus.resp_valid    <= 1'b1;
               bus.resp_rdata    <= 32'h0;
               bus.resp_misalign <= 1'b0;
            end
            ST_RESP: begin
               state         <= ST_IDLE;
               bus.req_ready <= 1'b1;
            end
            default: begin
               state         <= ST_IDLE;
               bus.req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors with a
// response scoreboard and memory-side spot checks.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct packed {
      logic [31:0] rdata;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // response monitor: pops the scoreboard on every resp_valid
   always @(negedge clk) begin
      if (bus.resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rdata %h expected no response",
                     bus.resp_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_misalign", {31'h0, bus.resp_misalign}, {31'h0, e.mis});
         end
      end
   end

   // mem_we must never stay high across two cycles
   logic we_prev;
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         chk("we_single", {31'h0, we_prev}, 32'h0);
      end
      we_prev <= bus.mem_we;
   end

   task automatic do_req(input op_e op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd,
                         input logic [31:0] exp_rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input bit exp_mis);
      int n;
      int lim;
      logic [31:0] a_prev;
      bit seen;
      bit we_seen;
      @(negedge clk);
      lim = 0;
      while (bus.req_ready !== 1'b1 && lim < 20) begin
         @(negedge clk);
         lim++;
      end
      if (lim >= 20) begin
         chk("ready_timeout", 32'h0, 32'h1);
      end
      a_prev        = bus.mem_a;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.mem_rd    = rd;
      bus.req_valid = 1'b1;
      exp_q.push_back('{rdata: exp_rd, mis: exp_mis});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      if (exp_mis) begin
         chk("mis_mem_a_kept", bus.mem_a, a_prev);
      end else begin
         chk("mem_a", bus.mem_a, {addr[31:2], 2'b00});
         chk("mem_be", {28'h0, bus.mem_byteenable}, {28'h0, exp_be});
         if (is_store(op)) chk("mem_wd", bus.mem_wd, exp_wd);
      end
      n       = 0;
      seen    = 1'b0;
      we_seen = (bus.mem_we === 1'b1);
      while (!seen && n < 10) begin
         if (bus.resp_valid === 1'b1) begin
            seen = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            n++;
            if (bus.mem_we === 1'b1) we_seen = 1'b1;
         end
      end
      if (!seen) chk("resp_timeout", 32'h0, 32'h1);
      if (!exp_mis && is_store(op)) chk("store_lat", n, 1);
      if (!exp_mis && !is_store(op)) chk("load_lat", n, 2);
      chk("mem_we_seen", {31'h0, we_seen},
          {31'h0, (!exp_mis && is_store(op))});
      @(negedge clk);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      we_prev       = 1'b0;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = OP_LB;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.mem_rd    = 32'h0;

      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_op    = op_e'($urandom_range(0, 7));
         bus.req_addr  = $urandom;
         bus.req_wdata = $urandom;
         bus.mem_rd    = $urandom;
         @(negedge clk);
         chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
         chk("rst_outs",
             bus.mem_a | bus.mem_wd | bus.resp_rdata |
             {bus.mem_byteenable, 25'h0, bus.mem_we,
              bus.resp_valid, bus.resp_misalign}, 32'h0);
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      do_req(OP_SW, 32'hBFC00010, 32'h11223344, 32'h0,
             32'h0, 4'b1111, 32'h11223344, 1'b0);
      do_req(OP_SB, 32'hBFC00013, 32'h000000AB, 32'h0,
             32'h0, 4'b0001, 32'hABABABAB, 1'b0);
      do_req(OP_SH, 32'hBFC00012, 32'h0000CAFE, 32'h0,
             32'h0, 4'b0011, 32'hCAFECAFE, 1'b0);
      do_req(OP_SH, 32'hBFC00020, 32'h00001234, 32'h0,
             32'h0, 4'b1100, 32'h12341234, 1'b0);
      do_req(OP_LB, 32'hBFC00011, 32'h0, 32'h1280FF00,
             32'hFFFFFF80, 4'b0100, 32'h0, 1'b0);
      do_req(OP_LBU, 32'hBFC00011, 32'h0, 32'h1280FF00,
             32'h00000080, 4'b0100, 32'h0, 1'b0);
      do_req(OP_LB, 32'hBFC00010, 32'h0, 32'h1280FF00,
             32'h00000012, 4'b1000, 32'h0, 1'b0);
      do_req(OP_LHU, 32'hBFC00012, 32'h0, 32'h00008001,
             32'h00008001, 4'b0011, 32'h0, 1'b0);
      do_req(OP_LH, 32'hBFC00012, 32'h0, 32'h00008001,
             32'hFFFF8001, 4'b0011, 32'h0, 1'b0);
      do_req(OP_LW, 32'hBFC00014, 32'h0, 32'hDEADBEEF,
             32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
      do_req(OP_LW, 32'hBFC00002, 32'h0, 32'h55555555,
             32'h0, 4'b0, 32'h0, 1'b1);
      do_req(OP_LH, 32'hBFC00001, 32'h0, 32'h55555555,
             32'h0, 4'b0, 32'h0, 1'b1);

      // reset in the middle of WRITE
      @(negedge clk);
      bus.req_op    = OP_SW;
      bus.req_addr  = 32'hBFC00040;
      bus.req_wdata = 32'hA5A5A5A5;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("wr_we_high", {31'h0, bus.mem_we}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("wr_we_async_drop", {31'h0, bus.mem_we}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("wr_rst_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("wr_rst_resp", {31'h0, bus.resp_valid}, 32'h0);

      // reset in the middle of WAIT
      bus.req_op    = OP_LW;
      bus.req_addr  = 32'hBFC00044;
      bus.mem_rd    = 32'h01020304;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("wait_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("wait_rst_ready", {31'h0, bus.req_ready}, 32'h1);

      // req_valid held through a busy load: one access only
      bus.req_op    = OP_LW;
      bus.req_addr  = 32'hBFC00048;
      bus.mem_rd    = 32'hCAFEF00D;
      bus.req_valid = 1'b1;
      exp_q.push_back('{rdata: 32'hCAFEF00D, mis: 1'b0});
      @(posedge clk);
      #1;
      bus.req_addr = 32'hBFC00080;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("busy_mem_a", bus.mem_a, 32'hBFC00048);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
